// File: rtl/risc_defs.sv
// ============================================================================
// Module      : risc_defs
// Description : Shared definitions for the 16-bit RISC pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package risc_defs;

    localparam int INSTR_W    = 16;
    localparam int OPCODE_W   = 3;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;

    localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] i_word);
        return i_word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic is_halt_word(input logic [INSTR_W-1:0] i_word);
        return i_word == HALT_WORD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : 2-entry FIFO with synchronous flush; the head drives dout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_count;
    logic              w_pop;
    logic              w_push;

    assign full   = (r_count == 2'd2);
    assign empty  = (r_count == 2'd0);
    assign dout   = r_mem[r_rd];
    // A push into a full queue is only accepted when the head leaves this cycle.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Fetch stage: PC, imem requests, 2-entry word queue, redirects.
//               Optional HALT_DETECT_EN stops fetch after a popped 16'hFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import risc_defs::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);

    fetch_state_e              r_state;
    logic [PC_W-1:0]           r_pc;
    logic [PC_W-1:0]           r_req_pc;
    logic                      r_epoch;
    logic                      r_tag;
    logic                      r_inflight;

    logic                      w_full;
    logic                      w_empty;
    logic [INSTR_W+PC_W-1:0]   w_head;
    logic [1:0]                w_occ;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_room;
    logic                      w_issue;
    logic                      w_redirect;
    logic                      w_halt_pop;
    logic                      w_flush;

    assign instr_valid = ~w_empty;
    assign instr       = w_head[INSTR_W+PC_W-1:PC_W];
    assign instr_pc    = w_head[PC_W-1:0];
    assign w_pop       = instr_valid & instr_ready;
    assign w_occ       = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);

`ifdef HALT_DETECT_EN
    assign w_redirect = redirect_valid & (r_state != ST_HALT);
    assign w_halt_pop = w_pop & (r_state == ST_RUN) & is_halt_word(instr) & ~w_redirect;
    assign halted     = (r_state == ST_HALT);
`else
    assign w_redirect = redirect_valid;
    assign w_halt_pop = 1'b0;
    assign halted     = 1'b0;
`endif

    // Issue only if the word can still land in the queue given what leaves now.
    assign w_room    = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_issue   = (r_state == ST_RUN) & ~w_redirect & w_room;
    assign imem_en   = w_issue;
    assign imem_addr = w_issue ? r_pc : '0;

    assign w_flush   = w_redirect | w_halt_pop;
    // Responses tagged with a stale epoch belong to a discarded fetch path.
    assign w_push    = r_inflight & (r_tag == r_epoch) & ~w_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_epoch    <= 1'b0;
            r_tag      <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_RUN;
                ST_RUN:  r_state <= w_halt_pop ? ST_HALT : ST_RUN;
                default: r_state <= r_state;
            endcase
            if (w_redirect) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_flush) begin
                r_epoch <= ~r_epoch;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag    <= r_epoch;
                r_req_pc <= r_pc;
            end
        end
    end

    fetch_queue #(
        .DATA_W (INSTR_W + PC_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   ({imem_rdata, r_req_pc}),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_head)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit (plus a RESET_PC=FE instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    typedef logic [23:0] exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        halted;

    logic        x_en;
    logic [7:0]  x_addr;
    logic [15:0] x_rdata = '0;
    logic        x_valid;
    logic        x_ready = 1'b1;
    logic [15:0] x_instr;
    logic [7:0]  x_pc;
    logic        x_halted;

    logic [15:0] mem [256];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          pops = 0;
    int          x_idx = 0;
    logic        stall_q = 1'b0;
    logic [15:0] stall_i = '0;
    logic [7:0]  stall_p = '0;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halted(halted)
    );

    fetch_unit #(.PC_W(8), .RESET_PC(8'hFE)) dut_w (
        .clk(clk), .rst(rst), .imem_en(x_en), .imem_addr(x_addr),
        .imem_rdata(x_rdata), .instr_valid(x_valid), .instr_ready(x_ready),
        .instr(x_instr), .instr_pc(x_pc), .redirect_valid(1'b0),
        .redirect_pc(8'h00), .halted(x_halted)
    );

    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];
    always @(posedge clk) if (x_en) x_rdata <= 16'hA000 + {8'h00, x_addr};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected delivery order after a (re)start: consecutive words from start.
    task automatic sb_restart(input logic [7:0] start);
        sb.delete();
        for (int i = 0; i < 512; i++) begin
            logic [7:0] a;
            a = start + i[7:0];
            sb.push_back({mem[a], a});
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (redirect_valid) check("no_req_on_redirect", {31'd0, imem_en}, 32'd0);
            if (stall_q) begin
                check("hold_valid", {31'd0, instr_valid}, 32'd1);
                check("hold_instr", {16'd0, instr}, {16'd0, stall_i});
                check("hold_pc", {24'd0, instr_pc}, {24'd0, stall_p});
            end
            if (instr_valid && instr_ready) begin
                pops++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h with nothing expected", instr_pc);
                end else begin
                    e = sb.pop_front();
                    if ({instr, instr_pc} !== e) begin
                        n_fail++;
                        $display("FAIL pop_word: got %h@%h expected %h@%h",
                                 instr, instr_pc, e[23:8], e[7:0]);
                    end
                end
            end
            stall_q = instr_valid && !instr_ready && !redirect_valid;
            stall_i = instr;
            stall_p = instr_pc;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            x_idx = 0;
        end else if (x_valid && x_idx < 4) begin
            logic [7:0] ep;
            ep = 8'hFE + x_idx[7:0];
            check("wrap_pc", {24'd0, x_pc}, {24'd0, ep});
            check("wrap_instr", {16'd0, x_instr}, {16'd0, 16'hA000 + {8'h00, ep}});
            x_idx++;
        end
    end

    task automatic do_reset(input logic rdy);
        @(posedge clk); #1;
        rst = 1'b1;
        instr_ready = rdy;
        redirect_valid = 1'b0;
        sb_restart(8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + i[15:0];
        sb_restart(8'h00);
        #12;
        check("rst_imem_en", {31'd0, imem_en}, 32'd0);
        check("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", {16'd0, instr}, 32'd0);
        check("rst_instr_pc", {24'd0, instr_pc}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        // Latency and streaming throughput
        instr_ready = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check("idle_no_req", {31'd0, imem_en}, 32'd0);
        @(posedge clk); #1;
        check("c1_req", {31'd0, imem_en}, 32'd1);
        check("c1_addr", {24'd0, imem_addr}, 32'd0);
        check("c1_valid", {31'd0, instr_valid}, 32'd0);
        @(posedge clk); #1;
        check("c2_valid", {31'd0, instr_valid}, 32'd0);
        @(posedge clk); #1;
        check("c3_valid", {31'd0, instr_valid}, 32'd1);
        check("c3_instr", {16'd0, instr}, 32'h0000A000);
        repeat (6) begin
            @(posedge clk); #1;
            check("stream_valid", {31'd0, instr_valid}, 32'd1);
        end

        // Backpressure
        do_reset(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_valid", {31'd0, instr_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_instr", {16'd0, instr}, 32'h0000A000);
            check("bp_no_req", {31'd0, imem_en}, 32'd0);
            @(posedge clk); #1;
        end
        instr_ready = 1'b1;
        base = pops;
        repeat (12) @(posedge clk);
        #1;
        check("bp_drain_count", pops - base, 32'd12);

        // Redirect with one word queued and one in flight
        do_reset(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rd_pre_valid", {31'd0, instr_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        @(negedge clk); #1;
        sb_restart(8'h40);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        check("rd_flushed", {31'd0, instr_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rd_valid", {31'd0, instr_valid}, 32'd1);
        check("rd_instr", {16'd0, instr}, 32'h0000A040);
        check("rd_pc", {24'd0, instr_pc}, 32'h40);

        // Randomized backpressure and redirects
        repeat (400) begin
            @(posedge clk); #1;
            redirect_valid = 1'b0;
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 11) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = 8'($urandom_range(0, 255));
                @(negedge clk); #1;
                sb_restart(redirect_pc);
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;

        // Asynchronous reset mid-stream
        instr_ready = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", {31'd0, instr_valid}, 32'd0);
        check("ar_imem_en", {31'd0, imem_en}, 32'd0);
        check("ar_instr", {16'd0, instr}, 32'd0);
        sb_restart(8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        base = pops;
        repeat (10) @(posedge clk);
        #1;
        check("ar_restart_count", pops - base, 32'd7);

`ifdef HALT_DETECT_EN
        mem[3] = 16'hFFFF;
        do_reset(1'b1);
        base = pops;
        t = 0;
        while (!halted && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        check("halt_seen", {31'd0, halted}, 32'd1);
        check("halt_words", pops - base, 32'd4);
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i == 5);
            redirect_pc = 8'h10;
            check("halt_no_req", {31'd0, imem_en}, 32'd0);
            check("halt_no_valid", {31'd0, instr_valid}, 32'd0);
            check("halt_stays", {31'd0, halted}, 32'd1);
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;
        mem[3] = 16'hA003;
`endif

        check("wrap_seen", x_idx, 32'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
